// File: rtl/dram_tx_dumper_if.sv
// DRAM read port, start trigger and UART outputs of the post-processing
// dump block, bundled so the board and the dumper share one connection.
interface dram_tx_dumper_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  start_Tx;
  logic [ADDR_WIDTH-1:0] dram_addr;
  logic                  dram_select;
  logic [7:0]            dram_data;
  logic                  tx;
  logic                  tx_busy;
  logic                  tx_done;

  // The dumper drives the DRAM address/select and the UART side.
  modport master (
    input  start_Tx,
    input  dram_data,
    output dram_addr,
    output dram_select,
    output tx,
    output tx_busy,
    output tx_done
  );

  // The board/control side supplies the trigger and DRAM read data.
  modport slave (
    output start_Tx,
    output dram_data,
    input  dram_addr,
    input  dram_select,
    input  tx,
    input  tx_busy,
    input  tx_done
  );
endinterface

// File: rtl/dram_tx_dumper.sv
// Reads NUM_BYTES bytes of DRAM starting at START_ADDR once the control
// state machine finishes, and sends each byte as an 8N1 UART frame.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a rising edge on start_Tx
// ADDR   | dram_addr presented to DRAM
// WAIT   | DRAM read latency cycle
// LATCH  | dram_data captured into the shift register
// START  | start bit (tx=0) for CLKS_PER_BIT cycles
// DATA   | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// STOP   | stop bit (tx=1); count the byte, fetch next or finish
// DONE   | dump finished; wait for start_Tx to drop
module dram_tx_dumper #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR   = '0,
  parameter int                    NUM_BYTES    = 256,
  parameter int                    CLKS_PER_BIT = 434
) (
  input logic               clock,
  input logic               reset,
  dram_tx_dumper_if.master  bus
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // Byte counter must represent NUM_BYTES itself (up to 2^ADDR_WIDTH).
  localparam int CNT_W  = $clog2(NUM_BYTES + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  NUM_BYTES_C = CNT_W'(NUM_BYTES);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_LATCH,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      remaining_q, remaining_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  select_q, select_d;
  logic                  done_q, done_d;
  logic                  start_prev_q, start_prev_d;
  logic                  trigger;
  logic                  baud_end;

  assign trigger  = bus.start_Tx & ~start_prev_q;
  assign baud_end = (baud_q == BAUD_LAST);

  // Next-state, counters and registered outputs for the dump sequence.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    baud_d       = baud_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    busy_d       = busy_q;
    select_d     = select_q;
    done_d       = done_q;
    start_prev_d = bus.start_Tx;

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d     = S_ADDR;
          addr_d      = START_ADDR;
          remaining_d = NUM_BYTES_C;
          busy_d      = 1'b1;
          select_d    = 1'b1;
        end
      end
      S_ADDR:  state_d = S_WAIT;
      S_WAIT:  state_d = S_LATCH;
      S_LATCH: begin
        shift_d   = bus.dram_data;
        baud_d    = '0;
        bit_idx_d = '0;
        state_d   = S_START;
      end
      S_START: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d      = '0;
          remaining_d = remaining_q - 1'b1;
          // Termination is by byte count only, so a window that wraps
          // the address space still sends exactly NUM_BYTES frames.
          if (remaining_q == CNT_ONE) begin
            state_d  = S_DONE;
            busy_d   = 1'b0;
            select_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_ADDR;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DONE: begin
        if (!bus.start_Tx) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // tx is registered from the state being entered so the line never
    // glitches on state decode.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset returns the line to idle at once.
  always_ff @(posedge clock) begin
    start_prev_q <= start_prev_d;
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= START_ADDR;
      remaining_q <= '0;
      baud_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      select_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      select_q    <= select_d;
      done_q      <= done_d;
    end
  end

  assign bus.dram_addr   = addr_q;
  assign bus.dram_select = select_q;
  assign bus.tx          = tx_q;
  assign bus.tx_busy     = busy_q;
  assign bus.tx_done     = done_q;

endmodule

// File: tb/tb_dram_tx_dumper.sv
// Directed bench for dram_tx_dumper: three instances cover a single-byte
// dump, a three-byte dump and an address-wrapping dump.
module tb_dram_tx_dumper;

  localparam int CPB   = 4;
  localparam int FRAME = 3 + 10 * CPB;  // 43 cycles per byte

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  dram_tx_dumper_if #(.ADDR_WIDTH(16)) if1 ();
  dram_tx_dumper_if #(.ADDR_WIDTH(16)) if3 ();
  dram_tx_dumper_if #(.ADDR_WIDTH(4))  ifw ();

  dram_tx_dumper #(.ADDR_WIDTH(16), .START_ADDR(16'd0), .NUM_BYTES(1), .CLKS_PER_BIT(CPB))
    u1 (.clock(clk), .reset(rst), .bus(if1));
  dram_tx_dumper #(.ADDR_WIDTH(16), .START_ADDR(16'd0), .NUM_BYTES(3), .CLKS_PER_BIT(CPB))
    u3 (.clock(clk), .reset(rst), .bus(if3));
  dram_tx_dumper #(.ADDR_WIDTH(4), .START_ADDR(4'd14), .NUM_BYTES(4), .CLKS_PER_BIT(CPB))
    uw (.clock(clk), .reset(rst), .bus(ifw));

  logic [7:0] mem1 [4];
  logic [7:0] mem3 [4];
  logic [7:0] memw [16];

  // Synchronous-read DRAM models: data valid one cycle after the address.
  always @(posedge clk) begin
    if1.dram_data <= mem1[if1.dram_addr[1:0]];
    if3.dram_data <= mem3[if3.dram_addr[1:0]];
    ifw.dram_data <= memw[ifw.dram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected tx level in cycle k after the trigger cycle (k=0), for n
  // bytes packed LSB-byte-first in 'bytes'.
  function automatic logic frame_tx(input int k, input logic [31:0] bytes, input int n);
    int j;
    int r;
    int b;
    if (k < 1 || k > n * FRAME) return 1'b1;
    j = (k - 1) / FRAME;
    r = (k - 1) % FRAME;
    if (r < 3) return 1'b1;
    b = (r - 3) / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return bytes[8 * j + b - 1];
  endfunction

  // One full single-byte dump on u1, with optional start_Tx pulse and
  // DRAM content change during the frame.
  task automatic run_byte1(input logic [7:0] b, input int pulse_at, input int poke_at,
                           input logic [7:0] poke_val, input string tag);
    int   e_tx;
    int   e_bs;
    int   e_dn;
    logic exp_tx;
    logic exp_busy;
    logic exp_done;
    e_tx = 0;
    e_bs = 0;
    e_dn = 0;
    if1.start_Tx = 1'b1;
    for (int k = 1; k <= FRAME + 1; k++) begin
      tick();
      exp_tx   = frame_tx(k, {24'h0, b}, 1);
      exp_busy = (k <= FRAME);
      exp_done = (k == FRAME + 1);
      if (if1.tx !== exp_tx) begin
        if (e_tx == 0) $display("FAIL %s_tx cycle %0d got %b expected %b", tag, k, if1.tx, exp_tx);
        e_tx++;
      end
      if (if1.tx_busy !== exp_busy || if1.dram_select !== exp_busy) begin
        if (e_bs == 0) $display("FAIL %s_busy_sel cycle %0d got busy=%b sel=%b expected %b",
                                tag, k, if1.tx_busy, if1.dram_select, exp_busy);
        e_bs++;
      end
      if (if1.tx_done !== exp_done) begin
        if (e_dn == 0) $display("FAIL %s_done cycle %0d got %b expected %b", tag, k, if1.tx_done, exp_done);
        e_dn++;
      end
      if (k == 1) begin
        checks++;
        if (if1.dram_addr !== 16'd0)
          $display("FAIL %s_addr got %0d expected 0", tag, if1.dram_addr);
        else passed++;
      end
      if (k == pulse_at) if1.start_Tx = 1'b0;
      if (k == pulse_at + 1) if1.start_Tx = 1'b1;
      if (k == poke_at) mem1[0] = poke_val;
    end
    checks++; if (e_tx == 0) passed++;
    checks++; if (e_bs == 0) passed++;
    checks++; if (e_dn == 0) passed++;
  endtask

  task automatic test_reset();
    int e;
    if1.start_Tx = 1'b0;
    if3.start_Tx = 1'b0;
    ifw.start_Tx = 1'b1;  // already high while reset is released
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (if1.tx !== 1'b1 || if1.tx_busy !== 1'b0 || if1.tx_done !== 1'b0 || if1.dram_select !== 1'b0)
      $display("FAIL reset_outputs got tx=%b busy=%b done=%b sel=%b expected 1 0 0 0",
               if1.tx, if1.tx_busy, if1.tx_done, if1.dram_select);
    else passed++;
    checks++;
    if (if1.dram_addr !== 16'd0) $display("FAIL reset_addr got %0d expected 0", if1.dram_addr);
    else passed++;
    checks++;
    if (ifw.dram_addr !== 4'd14) $display("FAIL reset_addr_w got %0d expected 14", ifw.dram_addr);
    else passed++;
    rst = 1'b0;
    e = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (ifw.tx_busy !== 1'b0 || ifw.tx !== 1'b1 || ifw.dram_select !== 1'b0) begin
        if (e == 0) $display("FAIL held_level_no_trigger cycle %0d got busy=%b tx=%b expected 0 1",
                             k, ifw.tx_busy, ifw.tx);
        e++;
      end
    end
    checks++; if (e == 0) passed++;
  endtask

  task automatic test_single_byte();
    mem1[0] = 8'hA5;
    run_byte1(8'hA5, -5, -5, 8'h00, "single");
  endtask

  task automatic test_hold_after_done();
    int e;
    e = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (if1.tx_busy !== 1'b0 || if1.tx_done !== 1'b1 || if1.tx !== 1'b1 || if1.dram_select !== 1'b0) begin
        if (e == 0) $display("FAIL hold_no_redump cycle %0d got busy=%b done=%b tx=%b expected 0 1 1",
                             k, if1.tx_busy, if1.tx_done, if1.tx);
        e++;
      end
    end
    checks++; if (e == 0) passed++;
    if1.start_Tx = 1'b0;
    tick();
    checks++;
    if (if1.tx_done !== 1'b0) $display("FAIL done_clear got %b expected 0", if1.tx_done);
    else passed++;
    tick();
  endtask

  task automatic test_mid_dump_retrigger();
    mem1[0] = 8'h5A;
    run_byte1(8'h5A, 15, -5, 8'h00, "midpulse");
    if1.start_Tx = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_data_stability();
    mem1[0] = 8'hC3;
    run_byte1(8'hC3, -5, 6, 8'h3C, "stability");
    if1.start_Tx = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_multi_byte();
    logic [31:0] bytes;
    int   e_tx;
    int   e_st;
    logic exp_busy;
    logic exp_done;
    logic exp_tx;
    bytes = {8'h00, 8'h3C, 8'hFF, 8'h00};
    e_tx = 0;
    e_st = 0;
    if3.start_Tx = 1'b1;
    for (int k = 1; k <= 3 * FRAME + 1; k++) begin
      tick();
      exp_tx   = frame_tx(k, bytes, 3);
      exp_busy = (k <= 3 * FRAME);
      exp_done = (k == 3 * FRAME + 1);
      if (if3.tx !== exp_tx) begin
        if (e_tx == 0) $display("FAIL multi_tx cycle %0d got %b expected %b", k, if3.tx, exp_tx);
        e_tx++;
      end
      if (if3.tx_busy !== exp_busy || if3.dram_select !== exp_busy || if3.tx_done !== exp_done) begin
        if (e_st == 0) $display("FAIL multi_status cycle %0d got busy=%b sel=%b done=%b expected %b %b %b",
                                k, if3.tx_busy, if3.dram_select, if3.tx_done, exp_busy, exp_busy, exp_done);
        e_st++;
      end
      if ((k - 1) % FRAME == 0 && k <= 3 * FRAME) begin
        checks++;
        if (if3.dram_addr !== 16'((k - 1) / FRAME))
          $display("FAIL multi_addr cycle %0d got %0d expected %0d", k, if3.dram_addr, (k - 1) / FRAME);
        else passed++;
      end
    end
    checks++; if (e_tx == 0) passed++;
    checks++; if (e_st == 0) passed++;
  endtask

  task automatic test_wrap();
    logic [31:0] bytes;
    int   e_tx;
    int   e_st;
    int   e_after;
    logic exp_busy;
    logic exp_done;
    logic exp_tx;
    memw[14] = 8'h11;
    memw[15] = 8'h22;
    memw[0]  = 8'h33;
    memw[1]  = 8'h44;
    bytes = {8'h44, 8'h33, 8'h22, 8'h11};
    e_tx = 0;
    e_st = 0;
    e_after = 0;
    ifw.start_Tx = 1'b0;
    tick();
    ifw.start_Tx = 1'b1;
    for (int k = 1; k <= 4 * FRAME + 1; k++) begin
      tick();
      exp_tx   = frame_tx(k, bytes, 4);
      exp_busy = (k <= 4 * FRAME);
      exp_done = (k == 4 * FRAME + 1);
      if (ifw.tx !== exp_tx) begin
        if (e_tx == 0) $display("FAIL wrap_tx cycle %0d got %b expected %b", k, ifw.tx, exp_tx);
        e_tx++;
      end
      if (ifw.tx_busy !== exp_busy || ifw.tx_done !== exp_done) begin
        if (e_st == 0) $display("FAIL wrap_status cycle %0d got busy=%b done=%b expected %b %b",
                                k, ifw.tx_busy, ifw.tx_done, exp_busy, exp_done);
        e_st++;
      end
      if ((k - 1) % FRAME == 0 && k <= 4 * FRAME) begin
        checks++;
        if (ifw.dram_addr !== 4'(14 + (k - 1) / FRAME))
          $display("FAIL wrap_addr cycle %0d got %0d expected %0d", k, ifw.dram_addr, (14 + (k - 1) / FRAME) % 16);
        else passed++;
      end
    end
    checks++; if (e_tx == 0) passed++;
    checks++; if (e_st == 0) passed++;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ifw.tx !== 1'b1 || ifw.tx_busy !== 1'b0 || ifw.tx_done !== 1'b1) begin
        if (e_after == 0) $display("FAIL wrap_stays_done cycle %0d got tx=%b busy=%b done=%b expected 1 0 1",
                                   k, ifw.tx, ifw.tx_busy, ifw.tx_done);
        e_after++;
      end
    end
    checks++; if (e_after == 0) passed++;
  endtask

  task automatic test_reset_mid();
    int e;
    mem1[0] = 8'h00;
    if1.start_Tx = 1'b1;
    for (int k = 1; k <= 21; k++) tick();
    checks++;
    if (if1.tx !== 1'b0 || if1.tx_busy !== 1'b1)
      $display("FAIL rstmid_pre got tx=%b busy=%b expected 0 1", if1.tx, if1.tx_busy);
    else passed++;
    rst = 1'b1;
    tick();
    checks++;
    if (if1.tx !== 1'b1 || if1.tx_busy !== 1'b0 || if1.dram_select !== 1'b0 || if1.tx_done !== 1'b0)
      $display("FAIL rstmid_post got tx=%b busy=%b sel=%b done=%b expected 1 0 0 0",
               if1.tx, if1.tx_busy, if1.dram_select, if1.tx_done);
    else passed++;
    rst = 1'b0;
    e = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (if1.tx !== 1'b1 || if1.tx_busy !== 1'b0) begin
        if (e == 0) $display("FAIL rstmid_no_resume cycle %0d got tx=%b busy=%b expected 1 0",
                             k, if1.tx, if1.tx_busy);
        e++;
      end
    end
    checks++; if (e == 0) passed++;
    if1.start_Tx = 1'b0;
    tick();
    mem1[0] = 8'h96;
    run_byte1(8'h96, -5, -5, 8'h00, "after_reset");
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mem1[i] = 8'h00;
      mem3[i] = 8'h00;
    end
    for (int i = 0; i < 16; i++) memw[i] = 8'hEE;
    mem3[0] = 8'h00;
    mem3[1] = 8'hFF;
    mem3[2] = 8'h3C;

    test_reset();
    test_single_byte();
    test_hold_after_done();
    test_mid_dump_retrigger();
    test_data_stability();
    test_multi_byte();
    test_wrap();
    test_reset_mid();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
